// File: rtl/aes_mc_pkg.sv
// Shared types, constants and GF(2^8) helpers for the sequential AES MixColumns engine.
// Coefficient words hold the coefficient for byte k at bits [8k+7:8k].
package aes_mc_pkg;

   typedef enum logic {
      MC_FWD = 1'b0,
      MC_INV = 1'b1
   } mc_mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mc_state_t;

   localparam logic [7:0]  AES_POLY    = 8'h1B;
   localparam logic [31:0] MC_FWD_COEF = 32'h01_01_03_02;
   localparam logic [31:0] MC_INV_COEF = 32'h09_0d_0b_0e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   // Shift-and-add multiply; constant coefficients collapse to a few xtime stages.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes_mc_row.sv
// One output byte of (Inv)MixColumns: the selected row's rotated coefficient
// vector dotted with a four-byte column in GF(2^8).
module aes_mc_row
   import aes_mc_pkg::*;
(
   input  logic [3:0] row_oh_i,
   input  logic       mode_i,
   input  logic [7:0] b0_i,
   input  logic [7:0] b1_i,
   input  logic [7:0] b2_i,
   input  logic [7:0] b3_i,
   output logic [7:0] byte_o
);

   logic [31:0] col_w;
   logic [31:0] rot_w;
   logic [31:0] coef_w;

   // Rotating the column left by r bytes is the same as rotating the coefficients right by r.
   always_comb begin
      col_w = {b3_i, b2_i, b1_i, b0_i};
      rot_w = col_w;
      if (row_oh_i[0])      rot_w = col_w;
      else if (row_oh_i[1]) rot_w = {col_w[7:0],  col_w[31:8]};
      else if (row_oh_i[2]) rot_w = {col_w[15:0], col_w[31:16]};
      else if (row_oh_i[3]) rot_w = {col_w[23:0], col_w[31:24]};

      coef_w = (mc_mode_t'(mode_i) == MC_INV) ? MC_INV_COEF : MC_FWD_COEF;

      byte_o = gf_mul(rot_w[7:0],   coef_w[7:0])
             ^ gf_mul(rot_w[15:8],  coef_w[15:8])
             ^ gf_mul(rot_w[23:16], coef_w[23:16])
             ^ gf_mul(rot_w[31:24], coef_w[31:24]);
   end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Byte-serial AES (Inv)MixColumns: accepts a block of NCOL columns, then streams
// 4*NCOL result bytes column-major with valid/ready flow control.
module aes_mix_columns_seq
   import aes_mc_pkg::*;
#(
   parameter int NCOL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [32*NCOL-1:0]   in_data,
   input  logic                 in_inv,
   input  logic                 in_bypass,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_data,
   output logic                 out_last
);

   localparam int              CW       = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam logic [CW-1:0]   LAST_COL = CW'(NCOL - 1);

   mc_state_t           state_q, state_d;
   logic [1:0]          row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic [32*NCOL-1:0]  data_q;
   mc_mode_t            mode_q;
   logic                bypass_q;

   logic                in_hs;
   logic                out_hs;
   logic                last_byte;
   logic [31:0]         col_word;
   logic [3:0]          row_oh;
   logic [7:0]          mc_byte;
   logic [7:0]          pass_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         data_q   <= '0;
         mode_q   <= MC_FWD;
         bypass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         if (in_hs) begin
            data_q   <= in_data;
            mode_q   <= in_inv ? MC_INV : MC_FWD;
            bypass_q <= in_bypass;
         end
      end
   end

   // A new block may be taken in the same cycle the final byte leaves, so there is no bubble.
   always_comb begin
      out_valid = (state_q == ST_RUN);
      last_byte = out_valid && (row_q == 2'd3) && (col_q == LAST_COL);
      in_ready  = (state_q == ST_IDLE) || (last_byte && out_ready);
      in_hs     = in_valid && in_ready;
      out_hs    = out_valid && out_ready;

      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;

      if (in_hs) begin
         state_d = ST_RUN;
         row_d   = 2'd0;
         col_d   = '0;
      end else if (out_hs) begin
         if (last_byte) begin
            state_d = ST_IDLE;
            row_d   = 2'd0;
            col_d   = '0;
         end else if (row_q == 2'd3) begin
            row_d = 2'd0;
            col_d = col_q + 1'b1;
         end else begin
            row_d = row_q + 2'd1;
         end
      end
   end

   always_comb begin
      col_word = data_q[31:0];
      for (int c = 0; c < NCOL; c++) begin
         if (col_q == CW'(c)) col_word = data_q[32*c +: 32];
      end
   end

   always_comb begin
      row_oh = 4'b0001 << row_q;
      case (row_q)
         2'd0:    pass_byte = col_word[7:0];
         2'd1:    pass_byte = col_word[15:8];
         2'd2:    pass_byte = col_word[23:16];
         default: pass_byte = col_word[31:24];
      endcase
   end

   aes_mc_row u_row (
      .row_oh_i (row_oh),
      .mode_i   (mode_q == MC_INV),
      .b0_i     (col_word[7:0]),
      .b1_i     (col_word[15:8]),
      .b2_i     (col_word[23:16]),
      .b3_i     (col_word[31:24]),
      .byte_o   (mc_byte)
   );

   always_comb begin
      out_data = out_valid ? (bypass_q ? pass_byte : mc_byte) : 8'h00;
      out_last = last_byte;
   end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed bench for aes_mix_columns_seq with one NCOL=1 and one NCOL=4 instance.
module tb_aes_mix_columns_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v1 = 1'b0, r1, inv1 = 1'b0, byp1 = 1'b0, ov1, or1 = 1'b1, ol1;
   logic [31:0] d1 = '0;
   logic [7:0]  od1;

   logic         v4 = 1'b0, r4, inv4 = 1'b0, byp4 = 1'b0, ov4, or4 = 1'b1, ol4;
   logic [127:0] d4 = '0;
   logic [7:0]   od4;

   int n_chk  = 0;
   int n_fail = 0;

   aes_mix_columns_seq #(.NCOL(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
      .in_inv(inv1), .in_bypass(byp1), .out_valid(ov1), .out_ready(or1),
      .out_data(od1), .out_last(ol1)
   );

   aes_mix_columns_seq #(.NCOL(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4),
      .in_inv(inv4), .in_bypass(byp4), .out_valid(ov4), .out_ready(or4),
      .out_data(od4), .out_last(ol4)
   );

   function automatic logic [31:0] col(input logic [7:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic test_reset();
      for (int ph = 0; ph < 2; ph++) begin
         repeat (2) @(negedge clk);
         #1;
         n_chk += 5;
         if (r1 !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready ph%0d got %b want 1", ph, r1); end
         if (ov1 !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid ph%0d got %b want 0", ph, ov1); end
         if (ol1 !== 1'b0)  begin n_fail++; $display("FAIL rst_out_last ph%0d got %b want 0", ph, ol1); end
         if (od1 !== 8'h00) begin n_fail++; $display("FAIL rst_out_data ph%0d got %h want 00", ph, od1); end
         if (r4 !== 1'b1 || ov4 !== 1'b0 || od4 !== 8'h00) begin
            n_fail++; $display("FAIL rst_ncol4 ph%0d got rdy=%b vld=%b data=%h want 1 0 00", ph, r4, ov4, od4);
         end
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   task automatic test_ncol1_modes();
      logic [31:0] din[4];
      logic [31:0] dexp[4];
      logic        inv[4];
      logic        byp[4];
      din[0] = col(8'hdb, 8'h13, 8'h53, 8'h45); dexp[0] = col(8'h8e, 8'h4d, 8'ha1, 8'hbc); inv[0] = 0; byp[0] = 0;
      din[1] = col(8'h8e, 8'h4d, 8'ha1, 8'hbc); dexp[1] = col(8'hdb, 8'h13, 8'h53, 8'h45); inv[1] = 1; byp[1] = 0;
      din[2] = col(8'hf2, 8'h0a, 8'h22, 8'h5c); dexp[2] = col(8'hf2, 8'h0a, 8'h22, 8'h5c); inv[2] = 1; byp[2] = 1;
      din[3] = col(8'hf2, 8'h0a, 8'h22, 8'h5c); dexp[3] = col(8'h9f, 8'hdc, 8'h58, 8'h9d); inv[3] = 0; byp[3] = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         v1 = 1'b1; d1 = din[t]; inv1 = inv[t]; byp1 = byp[t]; or1 = 1'b1;
         #1;
         n_chk++;
         if (r1 !== 1'b1) begin n_fail++; $display("FAIL mode%0d_accept in_ready got %b want 1", t, r1); end
         @(negedge clk);
         v1 = 1'b0; d1 = ~din[t]; inv1 = ~inv[t]; byp1 = ~byp[t];
         for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_chk += 4;
            if (ov1 !== 1'b1) begin n_fail++; $display("FAIL mode%0d_b%0d out_valid got %b want 1", t, i, ov1); end
            if (od1 !== dexp[t][8*i +: 8]) begin
               n_fail++; $display("FAIL mode%0d_b%0d out_data got %h want %h", t, i, od1, dexp[t][8*i +: 8]);
            end
            if (ol1 !== (i == 3)) begin n_fail++; $display("FAIL mode%0d_b%0d out_last got %b want %b", t, i, ol1, i == 3); end
            if (r1 !== (i == 3)) begin n_fail++; $display("FAIL mode%0d_b%0d in_ready got %b want %b", t, i, r1, i == 3); end
         end
         @(negedge clk);
         #1;
         n_chk++;
         if (ov1 !== 1'b0 || r1 !== 1'b1) begin
            n_fail++; $display("FAIL mode%0d_idle got vld=%b rdy=%b want 0 1", t, ov1, r1);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] dexp;
      dexp = col(8'h9f, 8'hdc, 8'h58, 8'h9d);
      @(negedge clk);
      v1 = 1'b1; d1 = col(8'hf2, 8'h0a, 8'h22, 8'h5c); inv1 = 1'b0; byp1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         or1 = 1'b0; d1 = $urandom; inv1 = ~inv1;
         #1;
         n_chk += 4;
         if (ov1 !== 1'b1) begin n_fail++; $display("FAIL bp_b%0d_stall out_valid got %b want 1", i, ov1); end
         if (od1 !== dexp[8*i +: 8]) begin n_fail++; $display("FAIL bp_b%0d_stall out_data got %h want %h", i, od1, dexp[8*i +: 8]); end
         if (ol1 !== (i == 3)) begin n_fail++; $display("FAIL bp_b%0d_stall out_last got %b want %b", i, ol1, i == 3); end
         if (r1 !== 1'b0) begin n_fail++; $display("FAIL bp_b%0d_stall in_ready got %b want 0", i, r1); end
         @(negedge clk);
         or1 = 1'b1;
         #1;
         n_chk += 3;
         if (od1 !== dexp[8*i +: 8]) begin n_fail++; $display("FAIL bp_b%0d_held out_data got %h want %h", i, od1, dexp[8*i +: 8]); end
         if (ol1 !== (i == 3)) begin n_fail++; $display("FAIL bp_b%0d_held out_last got %b want %b", i, ol1, i == 3); end
         if (r1 !== (i == 3)) begin n_fail++; $display("FAIL bp_b%0d_held in_ready got %b want %b", i, r1, i == 3); end
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bp_idle out_valid got %b want 0", ov1); end
   endtask

   task automatic test_ncol4();
      logic [127:0] e4;
      e4 = {col(8'h28, 8'h06, 8'h26, 8'h4c), col(8'h48, 8'hf8, 8'hd3, 8'h7a),
            col(8'he0, 8'hcb, 8'h19, 8'h9a), col(8'h04, 8'h66, 8'h81, 8'he5)};
      @(negedge clk);
      v4 = 1'b1; or4 = 1'b1; inv4 = 1'b0; byp4 = 1'b0;
      d4 = {col(8'h1e, 8'h27, 8'h98, 8'he5), col(8'hb8, 8'h41, 8'h11, 8'hf1),
            col(8'he0, 8'hb4, 8'h52, 8'hae), col(8'hd4, 8'hbf, 8'h5d, 8'h30)};
      @(negedge clk);
      v4 = 1'b0; d4 = '0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         n_chk += 3;
         if (ov4 !== 1'b1) begin n_fail++; $display("FAIL n4_b%0d out_valid got %b want 1", i, ov4); end
         if (od4 !== e4[8*i +: 8]) begin n_fail++; $display("FAIL n4_b%0d out_data got %h want %h", i, od4, e4[8*i +: 8]); end
         if (ol4 !== (i == 15)) begin n_fail++; $display("FAIL n4_b%0d out_last got %b want %b", i, ol4, i == 15); end
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (ov4 !== 1'b0 || r4 !== 1'b1) begin n_fail++; $display("FAIL n4_idle got vld=%b rdy=%b want 0 1", ov4, r4); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] eb;
      @(negedge clk);
      v1 = 1'b1; or1 = 1'b1; inv1 = 1'b0; byp1 = 1'b0; d1 = 32'hc6c6c6c6;
      @(negedge clk);
      d1 = 32'h01010101;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 4) v1 = 1'b0;
         eb = (k < 4) ? 8'hc6 : 8'h01;
         #1;
         n_chk += 4;
         if (ov1 !== 1'b1) begin n_fail++; $display("FAIL b2b_b%0d out_valid got %b want 1", k, ov1); end
         if (od1 !== eb) begin n_fail++; $display("FAIL b2b_b%0d out_data got %h want %h", k, od1, eb); end
         if (ol1 !== (k % 4 == 3)) begin n_fail++; $display("FAIL b2b_b%0d out_last got %b want %b", k, ol1, k % 4 == 3); end
         if (r1 !== (k % 4 == 3)) begin n_fail++; $display("FAIL b2b_b%0d in_ready got %b want %b", k, r1, k % 4 == 3); end
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (ov1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle out_valid got %b want 0", ov1); end
   endtask

   task automatic test_reset_midblock();
      @(negedge clk);
      v1 = 1'b1; or1 = 1'b1; d1 = col(8'hdb, 8'h13, 8'h53, 8'h45); inv1 = 1'b0; byp1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      #1;
      n_chk++;
      if (od1 !== 8'h8e) begin n_fail++; $display("FAIL rmid_b0 out_data got %h want 8e", od1); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk += 3;
      if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rmid_async out_valid got %b want 0", ov1); end
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL rmid_async in_ready got %b want 1", r1); end
      if (od1 !== 8'h00 || ol1 !== 1'b0) begin n_fail++; $display("FAIL rmid_async data/last got %h/%b want 00/0", od1, ol1); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_chk++;
         if (ov1 !== 1'b0 || od1 !== 8'h00) begin
            n_fail++; $display("FAIL rmid_after%0d got vld=%b data=%h want 0 00", k, ov1, od1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ncol1_modes();
      test_backpressure();
      test_ncol4();
      test_back_to_back();
      test_reset_midblock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_mix_columns_seq.md
AES_MIX_COLUMNS_SEQ -- requirements
Module: aes_mix_columns_seq

Interface
REQ-001 SHALL have parameter NCOL, default 4, meaning columns per block (legal 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, block offered.
REQ-005 SHALL have port in_ready, output, 1, block accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_data, input, 32*NCOL, the state columns; byte for row r, column c is at bits [32c+8r+7 : 32c+8r].
REQ-007 SHALL have port in_inv, input, 1; 0 selects forward MixColumns, 1 selects InvMixColumns.
REQ-008 SHALL have port in_bypass, input, 1; 1 passes bytes through unchanged (final AES round).
REQ-009 SHALL have port out_valid, output, 1, result byte present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the byte.
REQ-011 SHALL have port out_data, output, 8, result byte.
REQ-012 SHALL have port out_last, output, 1, high with the final byte of a block.

Function
REQ-013 SHALL use a two-state FSM: IDLE and RUN.
REQ-014 SHALL latch in_data, in_inv and in_bypass on acceptance, then enter RUN with row=0 and col=0.
REQ-015 SHALL drive out_valid high in RUN only, so the first byte is valid the cycle after acceptance.
REQ-016 SHALL emit bytes column-major: col 0 rows 0..3, then col 1, and so on. There are 4*NCOL bytes per block.
REQ-017 SHALL compute the forward row r byte as {02,03,01,01} rotated right by r, dot product with the column in GF(2^8), polynomial 0x11B.
REQ-018 SHALL compute the inverse row r byte with coefficients {0e,0b,0d,09} rotated right by r.
REQ-019 SHALL use xtime chains (shift plus conditional XOR 0x1B) for all multiplication, with no lookup tables.
REQ-020 SHALL hold out_data, out_last and the counters stable while out_valid is high and out_ready is low.
REQ-021 SHALL advance row on each output handshake. At row 3, row wraps to 0 and col increments.
REQ-022 SHALL assert out_last when row==3 and col==NCOL-1.
REQ-023 SHALL set in_ready = IDLE or (out_last and out_ready), giving back-to-back blocks with no bubble.
REQ-024 SHALL handle a final-byte handshake with a simultaneous input handshake by loading the new block, staying in RUN, and resetting the counters to 0.
REQ-025 SHALL return to IDLE on a final-byte handshake with no input handshake.
REQ-026 SHALL ignore in_data, in_inv and in_bypass when no input handshake occurs, including mid-block changes.
REQ-027 SHALL achieve a sustained throughput of one byte per cycle while out_ready is held high.

Reset
REQ-028 SHALL, while rst is high, force IDLE, row=0, col=0 and all latched data, mode and bypass registers to 0.
REQ-029 SHALL drive these outputs during and after reset: in_ready=1, out_valid=0, out_last=0, out_data=8'h00.
REQ-030 SHALL abort a block in progress on reset assertion, with no partial output after release.

Structure
REQ-031 SHALL place the following in shared package aes_mc_pkg: mode typedef (MC_FWD, MC_INV), state typedef, constant AES_POLY=8'h1B, and the forward and inverse coefficient constants.
REQ-032 SHALL instantiate one combinational sub-module, aes_mc_row (inputs: one-hot row select, mode, four bytes; output: one byte), once per design.

Verification
REQ-033 SHALL cover forward mode, NCOL=1: column db,13,53,45 -> out 8e,4d,a1,bc, with out_last on the 4th byte.
REQ-034 SHALL cover inverse mode, NCOL=1: column 8e,4d,a1,bc -> out db,13,53,45.
REQ-035 SHALL cover forward mode, NCOL=4: columns d4bf5d30 / e0b452ae / b84111f1 / 1e2798e5 (row0 first) -> 04668 1e5 / e0cb199a / 48f8d37a / 2806264c.
REQ-036 SHALL cover bypass with in_inv=1: column f2,0a,22,5c -> out f2,0a,22,5c unchanged; repeat with bypass=0 and in_inv=0 -> 9f,dc,58,9d.
REQ-037 SHALL cover back-pressure: out_ready toggled 1010 -> each byte held stable, no loss, identical result.
REQ-038 SHALL cover a back-to-back pair of blocks (c6c6c6c6 then 01010101) with in_valid held high -> 8 contiguous bytes c6x4, 01x4, and rst pulsed mid-block -> out_valid=0 and in_ready=1 immediately.
